// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter for one single-ported memory. Each port sees at least
// 3 cycles from request to its ready pulse, and a stalled port holds its request.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        stall_f,
    output logic        stall_m,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

    localparam logic [2:0] STREAK_LIM = 3'(STARVE_MAX);

    state_t     state;
    state_t     state_nx;
    logic [2:0] streak;
    logic       grant_dm;
    logic       grant_if;
    logic       done_if;
    logic       done_dm;
    logic       spurious;

    assign stall_f = if_req & ~if_ready;
    assign stall_m = dm_req & ~dm_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        done_if  = 1'b0;
        done_dm  = 1'b0;
        spurious = 1'b0;
        case (state)
            IDLE: begin
                spurious = mem_valid;
                // Data wins unless it has already starved a waiting fetch.
                if (dm_req && (!if_req || streak < STREAK_LIM)) begin
                    grant_dm = 1'b1;
                    state_nx = BUSY_DM;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_nx = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mem_valid) begin
                    done_if  = 1'b1;
                    state_nx = DONE;
                end
            end
            BUSY_DM: begin
                if (mem_valid) begin
                    done_dm  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                spurious = mem_valid;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak    <= 3'd0;
            proto_err <= 1'b0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            dm_rdata  <= 32'd0;
        end else begin
            mem_en   <= grant_dm | grant_if;
            if_ready <= done_if;
            dm_ready <= done_dm;
            if (grant_dm) begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= 32'd0;
            end
            if (done_if) begin
                if_rdata <= mem_rdata;
            end
            // mem_we is still the latched command qualifier here, so it marks loads.
            if (done_dm && !mem_we) begin
                dm_rdata <= mem_rdata;
            end
            if (grant_if) begin
                streak <= 3'd0;
            end else if (grant_dm && if_req && streak != 3'd7) begin
                streak <= streak + 3'd1;
            end
            if (spurious) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written sequences for contention, starvation, spurious completion and reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        stall_f;
    logic        stall_m;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        proto_err;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: answers each command after 'lat' cycles; cleared by rst.
    logic [31:0] mem [256];
    int          lat = 1;
    int          spur_cnt = 0;
    int          spur_done;
    logic        rp_pend;
    int          rp_cnt;
    logic [31:0] rp_addr;
    logic [31:0] rp_wdata;
    logic        rp_we;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h10] = 32'h00500093;
        mem[8'h40] = 32'h11112222;
        mem_valid = 1'b0;
        mem_rdata = 32'd0;
        rp_pend   = 1'b0;
        rp_cnt    = 0;
        spur_done = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            if (rst) begin
                rp_pend = 1'b0;
            end else if (rp_pend) begin
                if (rp_cnt <= 1) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem[rp_addr[7:0]];
                    if (rp_we) mem[rp_addr[7:0]] = rp_wdata;
                    rp_pend = 1'b0;
                end else begin
                    rp_cnt--;
                end
            end
            if (!mem_valid && spur_cnt != spur_done) begin
                mem_valid = 1'b1;
                mem_rdata = 32'h0BAD0BAD;
                spur_done++;
            end
            if (!rst && mem_en) begin
                rp_pend  = 1'b1;
                rp_cnt   = lat;
                rp_addr  = mem_addr;
                rp_we    = mem_we;
                rp_wdata = mem_wdata;
            end
        end
    end

    // Monitor: grant log and ready-pulse counts.
    logic [31:0] grant_addr [$];
    int          n_if_rdy = 0;
    int          n_dm_rdy = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_en) grant_addr.push_back(mem_addr);
            if (if_ready) n_if_rdy++;
            if (dm_ready) n_dm_rdy++;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_txn(input logic is_dm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int l,
                          output logic [31:0] g_addr, output logic g_we,
                          output logic [31:0] g_wdata, output int latency,
                          output int stall_bad);
        logic rdy;
        logic stl;
        g_addr    = 32'hFFFFFFFF;
        g_we      = 1'bx;
        g_wdata   = 32'hFFFFFFFF;
        latency   = -1;
        stall_bad = 0;
        lat = l;
        @(negedge clk);
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 1; k <= 40 && latency < 0; k++) begin
            @(negedge clk);
            rdy = is_dm ? dm_ready : if_ready;
            stl = is_dm ? stall_m : stall_f;
            if (mem_en) begin
                g_addr = mem_addr; g_we = mem_we; g_wdata = mem_wdata;
            end
            if (rdy) begin
                latency = k;
                if (stl !== 1'b0) stall_bad++;
            end else if (stl !== 1'b1) begin
                stall_bad++;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          l;
        logic [31:0] exp_rdata;
        int          exp_latency;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] starve_exp [10];
    logic [31:0] g_addr;
    logic        g_we;
    logic [31:0] g_wdata;
    int          latency;
    int          stall_bad;
    int          base;
    int          if0;
    int          dm0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        2, 32'h00500093, 4};
        vecs[1] = '{1'b1, 1'b0, 32'h40, 32'h0,        1, 32'h11112222, 3};
        vecs[2] = '{1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 1, 32'h11112222, 3};
        vecs[3] = '{1'b1, 1'b0, 32'h08, 32'h0,        3, 32'hDEADBEEF, 5};
        vecs[4] = '{1'b0, 1'b0, 32'h08, 32'h0,        1, 32'hDEADBEEF, 3};
        vecs[5] = '{1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 2, 32'hDEADBEEF, 4};
        vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        1, 32'hCAFEF00D, 3};
        for (int i = 0; i < 10; i++) starve_exp[i] = (i == 4 || i == 9) ? 32'h10 : 32'h40;

        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
        idle(2);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        chk("rst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst_stall", {30'd0, stall_f, stall_m}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            if0 = n_if_rdy; dm0 = n_dm_rdy; base = grant_addr.size();
            do_txn(vecs[i].is_dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].l,
                   g_addr, g_we, g_wdata, latency, stall_bad);
            idle(2);
            chk($sformatf("v%0d_latency", i), 32'(latency), 32'(vecs[i].exp_latency));
            chk($sformatf("v%0d_mem_addr", i), g_addr, vecs[i].addr);
            chk($sformatf("v%0d_mem_we", i), {31'd0, g_we}, {31'd0, vecs[i].is_dm & vecs[i].we});
            chk($sformatf("v%0d_mem_wdata", i), g_wdata,
                (vecs[i].is_dm && vecs[i].we) ? vecs[i].wdata : 32'd0);
            chk($sformatf("v%0d_rdata", i), vecs[i].is_dm ? dm_rdata : if_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_stall", i), 32'(stall_bad), 32'd0);
            chk($sformatf("v%0d_pulses", i), {16'(n_if_rdy - if0), 16'(n_dm_rdy - dm0)},
                vecs[i].is_dm ? 32'h0000_0001 : 32'h0001_0000);
            chk($sformatf("v%0d_grants", i), 32'(grant_addr.size() - base), 32'd1);
        end

        // Simultaneous requests: data first, then fetch.
        lat = 1;
        base = grant_addr.size();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        for (int k = 0; k < 60 && (if_req || dm_req); k++) begin
            @(negedge clk);
            if (if_ready) if_req = 1'b0;
            if (dm_ready) dm_req = 1'b0;
        end
        if_req = 1'b0; dm_req = 1'b0;
        idle(3);
        chk("sim_grants", 32'(grant_addr.size() - base), 32'd2);
        if (grant_addr.size() >= base + 2) begin
            chk("sim_first", grant_addr[base], 32'h40);
            chk("sim_second", grant_addr[base + 1], 32'h10);
        end
        chk("sim_streak", {29'd0, dut.streak}, 32'd0);
        chk("sim_dm_rdata", dm_rdata, 32'h11112222);
        chk("sim_if_rdata", if_rdata, 32'hCAFEF00D);

        // Starvation: both held; 4 data grants then 1 fetch, repeating.
        base = grant_addr.size();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        for (int k = 0; k < 200 && grant_addr.size() < base + 10; k++) begin
            @(negedge clk);
            #1;
        end
        if_req = 1'b0; dm_req = 1'b0;
        idle(10);
        chk("starve_grants", 32'(grant_addr.size() - base), 32'd10);
        if (grant_addr.size() >= base + 10) begin
            for (int i = 0; i < 10; i++)
                chk($sformatf("starve_g%0d", i), grant_addr[base + i], starve_exp[i]);
        end
        chk("starve_streak", {29'd0, dut.streak}, 32'd0);

        // Request dropped right after grant still completes.
        dm0 = n_dm_rdy;
        lat = 2;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h08;
        for (int k = 0; k < 10 && !mem_en; k++) @(negedge clk);
        dm_req = 1'b0;
        idle(8);
        chk("drop_dm_ready", 32'(n_dm_rdy - dm0), 32'd1);
        chk("drop_dm_rdata", dm_rdata, 32'hDEADBEEF);

        // Spurious completion in IDLE.
        chk("pre_proto_err", {31'd0, proto_err}, 32'd0);
        if0 = n_if_rdy; dm0 = n_dm_rdy;
        @(negedge clk);
        spur_cnt++;
        idle(4);
        chk("spur_proto_err", {31'd0, proto_err}, 32'd1);
        chk("spur_pulses", 32'((n_if_rdy - if0) + (n_dm_rdy - dm0)), 32'd0);
        chk("spur_if_rdata", if_rdata, 32'hCAFEF00D);
        chk("spur_dm_rdata", dm_rdata, 32'hDEADBEEF);
        do_txn(1'b0, 1'b0, 32'h40, 32'h0, 1, g_addr, g_we, g_wdata, latency, stall_bad);
        idle(2);
        chk("spur_fetch_latency", 32'(latency), 32'd3);
        chk("spur_fetch_rdata", if_rdata, 32'h11112222);
        chk("spur_sticky", {31'd0, proto_err}, 32'd1);

        // Reset while in BUSY_DM.
        dm0 = n_dm_rdy;
        lat = 5;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        for (int k = 0; k < 10 && !mem_en; k++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        chk("busy_rst_mem", {30'd0, mem_en, mem_we}, 32'd0);
        chk("busy_rst_addr", mem_addr | mem_wdata, 32'd0);
        chk("busy_rst_rdata", if_rdata | dm_rdata, 32'd0);
        chk("busy_rst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("busy_rst_proto_err", {31'd0, proto_err}, 32'd0);
        rst = 1'b0;
        idle(10);
        chk("busy_rst_no_ready", 32'(n_dm_rdy - dm0), 32'd0);
        do_txn(1'b1, 1'b0, 32'h40, 32'h0, 1, g_addr, g_we, g_wdata, latency, stall_bad);
        idle(2);
        chk("post_rst_latency", 32'(latency), 32'd3);
        chk("post_rst_rdata", dm_rdata, 32'h11112222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4; the maximum number of consecutive data-port grants allowed while a fetch is pending (legal range 1..7).
REQ-002 SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port if_req, input, 1 bit; instruction-fetch request, held until if_ready.
REQ-005 SHALL have port if_addr, input, 32 bits; fetch word address, held stable while if_req is high.
REQ-006 SHALL have port if_rdata, output, 32 bits; fetched instruction, registered.
REQ-007 SHALL have port if_ready, output, 1 bit; one-cycle completion pulse for the fetch port.
REQ-008 SHALL have port dm_req, input, 1 bit; data-memory request, held until dm_ready.
REQ-009 SHALL have port dm_we, input, 1 bit; 1 = write, 0 = read.
REQ-010 SHALL have port dm_addr, input, 32 bits; data word address.
REQ-011 SHALL have port dm_wdata, input, 32 bits; store data.
REQ-012 SHALL have port dm_rdata, output, 32 bits; load data, registered.
REQ-013 SHALL have port dm_ready, output, 1 bit; one-cycle completion pulse for the data port.
REQ-014 SHALL have port stall_f, output, 1 bit; combinational, equal to if_req & ~if_ready.
REQ-015 SHALL have port stall_m, output, 1 bit; combinational, equal to dm_req & ~dm_ready.
REQ-016 SHALL have port mem_en, output, 1 bit; one-cycle command strobe to the single-ported memory.
REQ-017 SHALL have port mem_we, output, 1 bit; write qualifier for mem_en.
REQ-018 SHALL have ports mem_addr and mem_wdata, output, 32 bits each; command address and data, registered.
REQ-019 SHALL have port mem_rdata, input, 32 bits; memory read data, valid when mem_valid is high.
REQ-020 SHALL have port mem_valid, input, 1 bit; memory completion pulse, arriving 1 or more cycles after mem_en.
REQ-021 SHALL have port proto_err, output, 1 bit; sticky protocol-error flag.

Function
REQ-022 SHALL implement the FSM states IDLE, BUSY_IF, BUSY_DM and DONE.
REQ-023 SHALL arbitrate only in IDLE; when neither request is high, it SHALL remain in IDLE.
REQ-024 SHALL grant the data port in IDLE when dm_req=1 and either if_req=0 or streak<STARVE_MAX.
REQ-025 SHALL grant the fetch port in IDLE when if_req=1 and the data port is not granted.
REQ-026 SHALL, on any grant at edge t, drive mem_en=1 for exactly cycle t+1 and latch mem_addr, mem_we and mem_wdata (mem_we=0 and mem_wdata=0 for fetches), then enter BUSY_IF or BUSY_DM.
REQ-027 SHALL hold mem_addr, mem_we and mem_wdata stable while in BUSY_IF or BUSY_DM.
REQ-028 SHALL, on mem_valid in BUSY_IF, load if_rdata from mem_rdata, pulse if_ready for the next cycle only, and enter DONE.
REQ-029 SHALL, on mem_valid in BUSY_DM, pulse dm_ready for the next cycle only, load dm_rdata from mem_rdata on reads only (dm_rdata unchanged on writes), and enter DONE.
REQ-030 SHALL move from DONE to IDLE unconditionally, with no arbitration in DONE; minimum request-to-ready latency is therefore 3 cycles.
REQ-031 SHALL keep a 3-bit counter streak that increments (saturating at 7) on each data grant made while if_req=1, and clears on each fetch grant.
REQ-032 SHALL grant the fetch port when if_req=1, dm_req=1 and streak==STARVE_MAX.
REQ-033 SHALL set proto_err on mem_valid=1 in IDLE or DONE, and SHALL ignore that pulse for data purposes.
REQ-034 SHALL hold proto_err high until rst.
REQ-035 SHALL NOT hold a request dropped mid-transaction; the transaction still completes and its ready pulse is still issued.

Reset
REQ-036 SHALL, while rst=1 at a rising edge, enter IDLE, clear streak and proto_err, and drive if_ready, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rdata and dm_rdata to 0.
REQ-037 SHALL, when reset is asserted mid-transaction, abandon the transaction with no ready pulse; the memory SHALL be reset together with this block.

Verification
REQ-038 SHALL cover a lone fetch: if_req=1, if_addr=0x10, mem_valid 2 cycles after mem_en with mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0, if_rdata=0x00500093, one if_ready pulse, stall_f=1 until that pulse.
REQ-039 SHALL cover simultaneous requests: if_req=1 and dm_req=1 (read 0x40) in the same IDLE cycle -> data port granted first, fetch granted after DONE, streak=0 at the end.
REQ-040 SHALL cover starvation: dm_req held high with if_req high and STARVE_MAX=4 -> 4 data grants, then 1 fetch grant, then data grants resume.
REQ-041 SHALL cover a store: dm_we=1, dm_addr=0x8, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF during the mem_en cycle, one dm_ready pulse, dm_rdata unchanged.
REQ-042 SHALL cover a spurious completion: mem_valid pulsed in IDLE -> proto_err=1 and stays 1 until rst; no ready pulse.
REQ-043 SHALL cover reset in BUSY_DM: rst pulsed -> IDLE on the next cycle, all outputs 0, no dm_ready pulse.
